// File: rtl/lpc_host.sv
// lpc_host: LPC host-side initiator for I/O Read and I/O Write cycles.
// It turns one local-bus request into an LPC frame (8-bit data, 16-bit
// address), waits for the peripheral's SYNC, and returns the read data and
// status.
// Build option LPC_HOST_WAIT_LIMIT_EN: when defined, the host also aborts
// after MAX_WAIT SYNC clocks, even while the peripheral keeps reporting wait
// states. When not defined, only NORESP_LIMIT clocks in a row with no valid
// SYNC nibble cause an abort.
module lpc_host #(
    parameter int NORESP_LIMIT = 3,
    parameter int MAX_WAIT     = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    output logic        lframe_o,
    inout  wire  [3:0]  lad_bus,
    input  logic        host_req_i,
    input  logic        host_wr_i,
    input  logic [15:0] host_addr_i,
    input  logic [7:0]  host_wdata_i,
    output logic        host_ready_o,
    output logic [7:0]  host_rdata_o,
    output logic        host_done_o,
    output logic        host_err_o
);

    localparam int NR_W   = $clog2(NORESP_LIMIT + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

`ifdef LPC_HOST_WAIT_LIMIT_EN
    localparam bit WAIT_LIMIT_EN = 1'b1;
`else
    localparam bit WAIT_LIMIT_EN = 1'b0;
`endif

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;
    localparam logic [3:0] CT_IO_RD   = 4'b0000;
    localparam logic [3:0] CT_IO_WR   = 4'b0010;
    localparam logic [3:0] NIB_ONES   = 4'b1111;
    // ABORT holds LFRAME# low for four clocks; the count runs 0..3.
    localparam logic [1:0] ABORT_LAST = 2'd3;

    typedef enum logic [4:0] {
        ST_IDLE, ST_START, ST_CYCTYPE, ST_ADDR3, ST_ADDR2, ST_ADDR1, ST_ADDR0,
        ST_WDATA_L, ST_WDATA_H, ST_TAR1, ST_TAR2, ST_SYNC, ST_RDATA_L,
        ST_RDATA_H, ST_FTAR1, ST_FTAR2, ST_ABORT
    } state_e;

    state_e             state_q;
    logic               lframe_q;
    logic               lad_oe_q;
    logic [3:0]         lad_out_q;
    logic               ready_q;
    logic               done_q;
    logic               err_q;
    logic [7:0]         rdata_q;
    logic [7:0]         rbuf_q;
    logic               wr_q;
    logic [15:0]        addr_q;
    logic [7:0]         wdata_q;
    logic               err_pend_q;
    logic [NR_W-1:0]    noresp_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [1:0]         abort_cnt_q;

    logic [3:0]         lad_in;
    logic               sync_ok;
    logic               sync_wait;
    logic               sync_abort;
    logic [NR_W-1:0]    noresp_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_d;

    assign lad_in       = lad_bus;
    assign lad_bus      = lad_oe_q ? lad_out_q : 4'bzzzz;
    assign lframe_o     = lframe_q;
    assign host_ready_o = ready_q;
    assign host_rdata_o = rdata_q;
    assign host_done_o  = done_q;
    assign host_err_o   = err_q;

    // Classify the SYNC nibble on LAD and form the counts that apply if this SYNC clock does not end the wait.
    always_comb begin
        sync_ok   = 1'b0;
        sync_wait = 1'b0;
        case (lad_in)
            SYNC_READY, SYNC_ERR: sync_ok   = 1'b1;
            SYNC_SHORT, SYNC_LONG: sync_wait = 1'b1;
            default: begin
                sync_ok   = 1'b0;
                sync_wait = 1'b0;
            end
        endcase
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (sync_wait) begin
            noresp_cnt_d = '0;
        end else begin
            noresp_cnt_d = noresp_cnt_q + NR_W'(1);
        end
        sync_abort = (noresp_cnt_d == NR_W'(NORESP_LIMIT)) ||
                     (WAIT_LIMIT_EN && (wait_cnt_d == WAIT_W'(MAX_WAIT)));
    end

    // Frame sequencer: each transition also loads the LFRAME#/LAD drive and status for the state it enters.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q      <= ST_IDLE;
            lframe_q     <= 1'b1;
            lad_oe_q     <= 1'b0;
            lad_out_q    <= 4'b0000;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 8'h00;
            rbuf_q       <= 8'h00;
            wr_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            err_pend_q   <= 1'b0;
            noresp_cnt_q <= '0;
            wait_cnt_q   <= '0;
            abort_cnt_q  <= 2'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (host_req_i) begin
                        state_q    <= ST_START;
                        ready_q    <= 1'b0;
                        lframe_q   <= 1'b0;
                        lad_oe_q   <= 1'b1;
                        lad_out_q  <= 4'b0000;
                        wr_q       <= host_wr_i;
                        addr_q     <= host_addr_i;
                        wdata_q    <= host_wdata_i;
                        err_pend_q <= 1'b0;
                    end else begin
                        ready_q  <= 1'b1;
                        lframe_q <= 1'b1;
                        lad_oe_q <= 1'b0;
                    end
                end
                ST_START: begin
                    state_q   <= ST_CYCTYPE;
                    lframe_q  <= 1'b1;
                    lad_out_q <= wr_q ? CT_IO_WR : CT_IO_RD;
                end
                ST_CYCTYPE: begin
                    state_q   <= ST_ADDR3;
                    lad_out_q <= addr_q[15:12];
                end
                ST_ADDR3: begin
                    state_q   <= ST_ADDR2;
                    lad_out_q <= addr_q[11:8];
                end
                ST_ADDR2: begin
                    state_q   <= ST_ADDR1;
                    lad_out_q <= addr_q[7:4];
                end
                ST_ADDR1: begin
                    state_q   <= ST_ADDR0;
                    lad_out_q <= addr_q[3:0];
                end
                ST_ADDR0: begin
                    if (wr_q) begin
                        state_q   <= ST_WDATA_L;
                        lad_out_q <= wdata_q[3:0];
                    end else begin
                        state_q   <= ST_TAR1;
                        lad_out_q <= NIB_ONES;
                    end
                end
                ST_WDATA_L: begin
                    state_q   <= ST_WDATA_H;
                    lad_out_q <= wdata_q[7:4];
                end
                ST_WDATA_H: begin
                    state_q   <= ST_TAR1;
                    lad_out_q <= NIB_ONES;
                end
                ST_TAR1: begin
                    state_q  <= ST_TAR2;
                    lad_oe_q <= 1'b0;
                end
                ST_TAR2: begin
                    state_q      <= ST_SYNC;
                    noresp_cnt_q <= '0;
                    wait_cnt_q   <= '0;
                end
                ST_SYNC: begin
                    if (sync_ok) begin
                        err_pend_q <= (lad_in == SYNC_ERR);
                        state_q    <= wr_q ? ST_FTAR1 : ST_RDATA_L;
                    end else if (sync_abort) begin
                        state_q     <= ST_ABORT;
                        lframe_q    <= 1'b0;
                        lad_oe_q    <= 1'b1;
                        lad_out_q   <= NIB_ONES;
                        abort_cnt_q <= 2'd0;
                    end else begin
                        noresp_cnt_q <= noresp_cnt_d;
                        wait_cnt_q   <= wait_cnt_d;
                    end
                end
                ST_RDATA_L: begin
                    state_q     <= ST_RDATA_H;
                    rbuf_q[3:0] <= lad_in;
                end
                ST_RDATA_H: begin
                    state_q     <= ST_FTAR1;
                    rbuf_q[7:4] <= lad_in;
                end
                ST_FTAR1: begin
                    state_q <= ST_FTAR2;
                end
                ST_FTAR2: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                    err_q   <= err_pend_q;
                    if (!wr_q) begin
                        rdata_q <= rbuf_q;
                    end else begin
                        rdata_q <= rdata_q;
                    end
                end
                ST_ABORT: begin
                    if (abort_cnt_q == ABORT_LAST) begin
                        state_q  <= ST_IDLE;
                        lframe_q <= 1'b1;
                        lad_oe_q <= 1'b0;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        abort_cnt_q <= abort_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    lframe_q <= 1'b1;
                    lad_oe_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: randomized, self-checking bench for lpc_host. A frame-level
// reference model expands each request into per-clock expectations for
// LFRAME#, LAD and status, and plays the peripheral side of LAD.
module tb_lpc_host;

    localparam int NORESP_LIMIT = 3;
    localparam int MAX_WAIT     = 64;
`ifdef LPC_HOST_WAIT_LIMIT_EN
    localparam bit WAIT_LIMIT_EN = 1'b1;
`else
    localparam bit WAIT_LIMIT_EN = 1'b0;
`endif
    // Value the bench puts on LAD whenever the host must have released it.
    localparam logic [3:0] REL = 4'b0000;

    logic        clk_i;
    logic        nrst_i;
    logic        lframe_o;
    wire  [3:0]  lad_bus;
    logic        host_req_i;
    logic        host_wr_i;
    logic [15:0] host_addr_i;
    logic [7:0]  host_wdata_i;
    logic        host_ready_o;
    logic [7:0]  host_rdata_o;
    logic        host_done_o;
    logic        host_err_o;

    logic        tb_oe;
    logic [3:0]  tb_out;
    assign lad_bus = tb_oe ? tb_out : 4'bzzzz;

    int chk_cnt;
    int err_cnt;
    logic [7:0] model_rdata;

    // Peripheral SYNC replies in order; the last one repeats forever.
    logic [3:0] sync_q[$];
    // Per-clock expectations, indexed from the START clock.
    bit         m_drv[$];
    logic [3:0] m_val[$];
    bit         m_lf[$];
    bit         m_son[$];
    logic [3:0] m_sval[$];

    lpc_host #(.NORESP_LIMIT(NORESP_LIMIT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .lframe_o(lframe_o), .lad_bus(lad_bus),
        .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_ready_o(host_ready_o),
        .host_rdata_o(host_rdata_o), .host_done_o(host_done_o), .host_err_o(host_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic void push(input bit drv, input logic [3:0] val, input bit lf,
                                 input bit son, input logic [3:0] sval);
        m_drv.push_back(drv);
        m_val.push_back(val);
        m_lf.push_back(lf);
        m_son.push_back(son);
        m_sval.push_back(sval);
    endfunction

    // One transfer: build the expected frame, then play it clock by clock.
    // rst_at >= 0 pulses nrst_i at that clock index and ends the transfer.
    task automatic xfer(input string name, input bit wr, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata,
                        input bit hold, input int rst_at);
        bit aborted;
        bit got_err;
        bit finished;
        bit exp_err;
        int nr;
        int total;
        logic [3:0] nib;
        logic [3:0] exp_lad;
        logic [7:0] exp_rdata;
        m_drv.delete(); m_val.delete(); m_lf.delete(); m_son.delete(); m_sval.delete();
        push(1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
        push(1'b1, wr ? 4'h2 : 4'h0, 1'b1, 1'b0, 4'h0);
        push(1'b1, addr[15:12], 1'b1, 1'b0, 4'h0);
        push(1'b1, addr[11:8], 1'b1, 1'b0, 4'h0);
        push(1'b1, addr[7:4], 1'b1, 1'b0, 4'h0);
        push(1'b1, addr[3:0], 1'b1, 1'b0, 4'h0);
        if (wr) begin
            push(1'b1, wdata[3:0], 1'b1, 1'b0, 4'h0);
            push(1'b1, wdata[7:4], 1'b1, 1'b0, 4'h0);
        end
        push(1'b1, 4'hF, 1'b1, 1'b0, 4'h0);
        push(1'b0, 4'h0, 1'b1, 1'b1, REL);
        aborted = 1'b0; got_err = 1'b0; finished = 1'b0; nr = 0; total = 0;
        for (int s = 0; s < 1000 && !finished; s++) begin
            nib = sync_q[(s < sync_q.size()) ? s : sync_q.size() - 1];
            push(1'b0, 4'h0, 1'b1, 1'b1, nib);
            total++;
            if (nib == 4'h0 || nib == 4'hA) begin
                got_err  = (nib == 4'hA);
                finished = 1'b1;
            end else begin
                nr = (nib == 4'h5 || nib == 4'h6) ? 0 : nr + 1;
                if (nr == NORESP_LIMIT || (WAIT_LIMIT_EN && total == MAX_WAIT)) begin
                    aborted  = 1'b1;
                    finished = 1'b1;
                end
            end
        end
        if (aborted) begin
            for (int k = 0; k < 4; k++) push(1'b1, 4'hF, 1'b0, 1'b0, 4'h0);
        end else begin
            if (!wr) begin
                push(1'b0, 4'h0, 1'b1, 1'b1, rdata[3:0]);
                push(1'b0, 4'h0, 1'b1, 1'b1, rdata[7:4]);
            end
            push(1'b0, 4'h0, 1'b1, 1'b1, 4'hF);
            push(1'b0, 4'h0, 1'b1, 1'b1, REL);
        end
        exp_err   = aborted || got_err;
        exp_rdata = (!wr && !aborted) ? rdata : model_rdata;

        tb_oe = 1'b0;
        host_wr_i = wr; host_addr_i = addr; host_wdata_i = wdata; host_req_i = 1'b1;
        @(posedge clk_i);
        for (int n = 0; n < m_drv.size(); n++) begin
            @(negedge clk_i);
            if (!hold) host_req_i = 1'b0;
            tb_oe = m_son[n]; tb_out = m_sval[n];
            #1;
            if (n == rst_at) begin
                nrst_i = 1'b0; tb_oe = 1'b1; tb_out = REL;
                #1;
                model_rdata = 8'h00;
                chk_cnt++;
                if (lframe_o !== 1'b1 || lad_bus !== REL || host_ready_o !== 1'b1 ||
                    host_done_o !== 1'b0 || host_err_o !== 1'b0 || host_rdata_o !== 8'h00) begin
                    err_cnt++;
                    $display("FAIL %s reset@%0d: lframe=%b lad=%h ready=%b done=%b err=%b rdata=%h, want 1 %h 1 0 0 00",
                             name, n, lframe_o, lad_bus, host_ready_o, host_done_o, host_err_o, host_rdata_o, REL);
                end
                @(negedge clk_i);
                nrst_i = 1'b1;
                return;
            end
            exp_lad = m_drv[n] ? m_val[n] : m_sval[n];
            chk_cnt++;
            if (lframe_o !== m_lf[n] || lad_bus !== exp_lad || host_done_o !== 1'b0 ||
                host_ready_o !== 1'b0 || host_err_o !== 1'b0 || host_rdata_o !== model_rdata) begin
                err_cnt++;
                $display("FAIL %s clk%0d: lframe=%b lad=%h done=%b ready=%b err=%b rdata=%h, want lframe=%b lad=%h done=0 ready=0 err=0 rdata=%h",
                         name, n, lframe_o, lad_bus, host_done_o, host_ready_o, host_err_o, host_rdata_o,
                         m_lf[n], exp_lad, model_rdata);
            end
        end
        @(negedge clk_i);
        tb_oe = 1'b1; tb_out = REL;
        #1;
        chk_cnt++;
        if (host_done_o !== 1'b1 || host_err_o !== exp_err || host_ready_o !== 1'b1 ||
            lframe_o !== 1'b1 || lad_bus !== REL || host_rdata_o !== exp_rdata) begin
            err_cnt++;
            $display("FAIL %s done@%0d: done=%b err=%b ready=%b lframe=%b lad=%h rdata=%h, want 1 %b 1 1 %h %h",
                     name, m_drv.size(), host_done_o, host_err_o, host_ready_o, lframe_o, lad_bus,
                     host_rdata_o, exp_err, REL, exp_rdata);
        end
        model_rdata = exp_rdata;
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #2;
        chk_cnt++;
        if (lframe_o !== 1'b1 || lad_bus !== REL || host_ready_o !== 1'b1 || host_done_o !== 1'b0 ||
            host_err_o !== 1'b0 || host_rdata_o !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_state: lframe=%b lad=%h ready=%b done=%b err=%b rdata=%h, want 1 %h 1 0 0 00",
                     lframe_o, lad_bus, host_ready_o, host_done_o, host_err_o, host_rdata_o, REL);
        end
        @(negedge clk_i);
        nrst_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk_cnt++;
        if (lframe_o !== 1'b1 || host_ready_o !== 1'b1 || host_done_o !== 1'b0 || lad_bus !== REL) begin
            err_cnt++;
            $display("FAIL idle_after_reset: lframe=%b ready=%b done=%b lad=%h, want 1 1 0 %h",
                     lframe_o, host_ready_o, host_done_o, lad_bus, REL);
        end
    endtask

    task automatic test_write_basic();
        sync_q = '{4'h0};
        xfer("write_0080", 1'b1, 16'h0080, 8'hA5, 8'h00, 1'b0, -1);
    endtask

    task automatic test_read_wait();
        sync_q = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h0};
        xfer("read_002E_wait", 1'b0, 16'h002E, 8'h00, 8'hC3, 1'b0, -1);
        sync_q = '{4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'h0};
        xfer("read_noresp_cleared", 1'b0, 16'h1357, 8'h00, 8'h69, 1'b0, -1);
    endtask

    task automatic test_noresp_abort();
        sync_q = '{4'hF};
        xfer("read_noresp_abort", 1'b0, 16'h1234, 8'h00, 8'h5A, 1'b0, -1);
        sync_q = '{4'h9};
        xfer("write_bad_sync_abort", 1'b1, 16'hBEEF, 8'h3C, 8'h00, 1'b0, -1);
    endtask

    task automatic test_sync_error();
        sync_q = '{4'hA};
        xfer("write_sync_err", 1'b1, 16'h0060, 8'h7E, 8'h00, 1'b0, -1);
        sync_q = '{4'h6, 4'hA};
        xfer("read_sync_err", 1'b0, 16'h0064, 8'h00, 8'h81, 1'b0, -1);
    endtask

    task automatic test_reset_midcycle();
        sync_q = '{4'h0};
        xfer("write_reset_addr1", 1'b1, 16'h4321, 8'h99, 8'h00, 1'b0, 4);
        xfer("write_after_reset", 1'b1, 16'h4321, 8'h99, 8'h00, 1'b0, -1);
        xfer("read_after_reset", 1'b0, 16'h0071, 8'h00, 8'hE4, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        sync_q = '{4'h0};
        xfer("b2b_write", 1'b1, 16'h03F8, 8'h11, 8'h00, 1'b1, -1);
        xfer("b2b_read", 1'b0, 16'h03F9, 8'h00, 8'h22, 1'b1, -1);
        xfer("b2b_last", 1'b1, 16'h03FA, 8'h33, 8'h00, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [3:0] pool[4];
        pool[0] = 4'h5; pool[1] = 4'h6; pool[2] = 4'hF; pool[3] = 4'hC;
        for (int i = 0; i < 10; i++) begin
            sync_q.delete();
            for (int w = 0; w < int'($urandom_range(0, 5)); w++)
                sync_q.push_back(pool[$urandom_range(0, 3)]);
            sync_q.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
            xfer("random", 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1);
        end
    endtask

    task automatic test_wait_limit();
        sync_q.delete();
        for (int w = 0; w < 200; w++) sync_q.push_back(4'h6);
        sync_q.push_back(4'h0);
        xfer("read_long_wait", 1'b0, 16'h0CF8, 8'h00, 8'hD7, 1'b0, -1);
    endtask

    initial begin
        chk_cnt = 0; err_cnt = 0; model_rdata = 8'h00;
        nrst_i = 1'b0; host_req_i = 1'b0; host_wr_i = 1'b0;
        host_addr_i = 16'h0000; host_wdata_i = 8'h00;
        tb_oe = 1'b1; tb_out = REL;
        test_reset();
        test_write_basic();
        test_read_wait();
        test_noresp_abort();
        test_sync_error();
        test_reset_midcycle();
        test_back_to_back();
        test_random();
        test_wait_limit();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
